// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_unit_pkg : shared types and constants for the fetch stage          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam int          NOP_INSTR        = 0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder : generic unsigned modulo-2^WIDTH adder                               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule : adder
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_unit : instruction fetch stage with IF/ID register, driving a      |
// |                 variable-latency instruction memory request port           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [DATA_W-1:0] if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              issue;

  adder #(
    .WIDTH (ADDR_W)
  ) u_pc_adder (
    .a   (pc_q),
    .b   (ADDR_W'(PC_STEP)),
    .sum (pc_inc)
  );

  // A new address is only launched from IDLE; BUSY/DROP keep the issued one alive.
  assign issue = (state_q == ST_IDLE) && !freeze;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = req_addr_q;
    case (state_q)
      ST_IDLE: begin
        imem_req  = !freeze;
        imem_addr = pc_q;
      end
      ST_BUSY, ST_DROP: imem_req = 1'b1;
      default:          imem_req = 1'b0;
    endcase
    if (rst) imem_req = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    skid_d        = skid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (branch_taken) begin
      // Flush wins over freeze and over any response landing this cycle.
      pc_d          = branch_address;
      if_id_pc_d    = '0;
      if_id_instr_d = DATA_W'(NOP_INSTR);
      if_id_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) req_addr_d = pc_q;
          state_d = (issue && !imem_ready) ? ST_DROP : ST_IDLE;
        end
        ST_BUSY, ST_DROP: state_d = imem_ready ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            req_addr_d = pc_q;
            if (imem_ready) begin
              if_id_pc_d    = pc_inc;
              if_id_instr_d = imem_rdata;
              if_id_valid_d = 1'b1;
              pc_d          = pc_inc;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (imem_ready && !freeze) begin
            if_id_pc_d    = pc_inc;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
            state_d       = ST_IDLE;
          end else if (imem_ready) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_ready) state_d = ST_IDLE;
        end
        default: begin
          if (!freeze) begin
            if_id_pc_d    = pc_inc;
            if_id_instr_d = skid_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
            state_d       = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      skid_q        <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      skid_q        <= skid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule : if_fetch_unit
`default_nettype wire
